// File: rtl/irq_pending_ctrl.sv
// irq_pending_ctrl
// Captures one-cycle event pulses into sticky pending bits. It presents the
// lowest-numbered enabled pending source to the core as a level request with
// an ID, and retires that source on a one-cycle acknowledge.
//
// Optional feature: define IRQ_OVF_CNT_EN to build the saturating 8-bit
// lost-event counter on ovf_cnt. Without it, ovf_cnt is tied to zero.
module irq_pending_ctrl #(
    parameter int NSRC = 4,
    parameter int ID_W = 2
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [NSRC-1:0] pulse_in,
    input  logic [NSRC-1:0] mask_in,
    input  logic            irq_ack,
    output logic            irq,
    output logic [ID_W-1:0] irq_id,
    output logic [NSRC-1:0] pending,
    output logic [7:0]      ovf_cnt
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_GAP  = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic            irq_q, irq_d;
    logic [ID_W-1:0] irq_id_q, irq_id_d;
    logic [NSRC-1:0] pending_q, pending_d;
    logic [NSRC-1:0] clr_vec;
    logic [NSRC-1:0] req_vec;
    logic            found;
    logic [ID_W-1:0] low_id;

    // Find the lowest-indexed pending source that is also enabled.
    always_comb begin
        req_vec = pending_q & mask_in;
        found   = 1'b0;
        low_id  = '0;
        for (int i = NSRC - 1; i >= 0; i--) begin
            if (req_vec[i]) begin
                found  = 1'b1;
                low_id = ID_W'(i);
            end
        end
    end

    // Request FSM. The ID is latched once on entry to REQ and never re-arbitrated until ack.
    always_comb begin
        state_d  = state_q;
        irq_d    = irq_q;
        irq_id_d = irq_id_q;
        clr_vec  = '0;
        case (state_q)
            ST_IDLE: begin
                irq_d = 1'b0;
                if (found) begin
                    state_d  = ST_REQ;
                    irq_d    = 1'b1;
                    irq_id_d = low_id;
                end
            end
            ST_REQ: begin
                if (irq_ack) begin
                    state_d = ST_GAP;
                    irq_d   = 1'b0;
                    clr_vec = NSRC'(1) << irq_id_q;
                end
            end
            ST_GAP: begin
                state_d = ST_IDLE;
                irq_d   = 1'b0;
            end
            default: begin
                state_d = ST_IDLE;
                irq_d   = 1'b0;
            end
        endcase
    end

    // Sticky pending bits. A new pulse wins over a same-cycle clear.
    always_comb begin
        pending_d = (pending_q & ~clr_vec) | pulse_in;
    end

    // Register FSM state, request outputs and pending bits.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            irq_q     <= 1'b0;
            irq_id_q  <= '0;
            pending_q <= '0;
        end else begin
            state_q   <= state_d;
            irq_q     <= irq_d;
            irq_id_q  <= irq_id_d;
            pending_q <= pending_d;
        end
    end

`ifdef IRQ_OVF_CNT_EN
    logic       lost;
    logic [7:0] ovf_cnt_q, ovf_cnt_d;

    // One increment per cycle with any lost event, saturating at 255.
    always_comb begin
        lost      = |(pulse_in & pending_q & ~clr_vec);
        ovf_cnt_d = ovf_cnt_q;
        if (lost && (ovf_cnt_q != 8'hFF)) begin
            ovf_cnt_d = ovf_cnt_q + 8'd1;
        end
    end

    // Lost-event counter register; only reset clears it.
    always_ff @(posedge clk) begin
        if (reset) begin
            ovf_cnt_q <= 8'd0;
        end else begin
            ovf_cnt_q <= ovf_cnt_d;
        end
    end

    assign ovf_cnt = ovf_cnt_q;
`else
    assign ovf_cnt = 8'd0;
`endif

    assign irq     = irq_q;
    assign irq_id  = irq_id_q;
    assign pending = pending_q;

endmodule

// File: tb/tb_irq_pending_ctrl.sv
// Directed testbench for irq_pending_ctrl with hand-computed expectations.
module tb_irq_pending_ctrl;

    localparam int NSRC = 4;
    localparam int ID_W = 2;
`ifdef IRQ_OVF_CNT_EN
    localparam bit OVF_EN = 1'b1;
`else
    localparam bit OVF_EN = 1'b0;
`endif

    logic            clk = 1'b0;
    logic            reset;
    logic [NSRC-1:0] pulse_in;
    logic [NSRC-1:0] mask_in;
    logic            irq_ack;
    logic            irq;
    logic [ID_W-1:0] irq_id;
    logic [NSRC-1:0] pending;
    logic [7:0]      ovf_cnt;

    int total = 0;
    int bad   = 0;

    irq_pending_ctrl #(.NSRC(NSRC), .ID_W(ID_W)) dut (
        .clk      (clk),
        .reset    (reset),
        .pulse_in (pulse_in),
        .mask_in  (mask_in),
        .irq_ack  (irq_ack),
        .irq      (irq),
        .irq_id   (irq_id),
        .pending  (pending),
        .ovf_cnt  (ovf_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Advance one clock edge and settle 1 time unit after it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset    = 1'b1;
        pulse_in = '0;
        mask_in  = 4'hF;
        irq_ack  = 1'b0;
        step();
        step();
        check("rst_irq", irq, 0);
        check("rst_id", irq_id, 0);
        check("rst_pend", pending, 0);
        check("rst_ovf", ovf_cnt, 0);
        reset = 1'b0;

        // Single pulse on source 2: pending after 1 edge, irq after 2.
        pulse_in = 4'b0100;
        step();
        pulse_in = '0;
        check("t1_pend", pending, 4'b0100);
        check("t1_irq_early", irq, 0);
        step();
        check("t1_irq", irq, 1);
        check("t1_id", irq_id, 2);
        irq_ack = 1'b1;
        step();
        irq_ack = 1'b0;
        check("t1_ack_irq", irq, 0);
        check("t1_ack_pend", pending, 0);
        step();
        step();
        check("t1_quiet", irq, 0);

        // Sources 3 and 1 together: 1 first, then 3 after the gap.
        pulse_in = 4'b1010;
        step();
        pulse_in = '0;
        check("t2_pend0", pending, 4'b1010);
        step();
        check("t2_irq1", irq, 1);
        check("t2_id1", irq_id, 1);
        irq_ack = 1'b1;
        step();
        irq_ack = 1'b0;
        check("t2_gap_irq", irq, 0);
        check("t2_pend1", pending, 4'b1000);
        step();
        check("t2_idle_irq", irq, 0);
        step();
        check("t2_irq3", irq, 1);
        check("t2_id3", irq_id, 3);
        irq_ack = 1'b1;
        step();
        irq_ack = 1'b0;
        check("t2_pend2", pending, 4'b0000);
        check("t2_irq_off", irq, 0);
        step();
        step();

        // Masked source 0 latches but does not request.
        mask_in  = 4'b1110;
        pulse_in = 4'b0001;
        step();
        pulse_in = '0;
        step();
        step();
        check("t3_pend", pending, 4'b0001);
        check("t3_masked", irq, 0);
        mask_in = 4'b1111;
        step();
        step();
        check("t3_irq", irq, 1);
        check("t3_id", irq_id, 0);
        mask_in = 4'b0000;
        step();
        step();
        check("t3_hold", irq, 1);
        irq_ack = 1'b1;
        step();
        irq_ack = 1'b0;
        check("t3_ack_irq", irq, 0);
        check("t3_ack_pend", pending, 0);
        mask_in = 4'hF;
        step();
        step();

        // Set-wins: pulse on source 2 coincides with its ack.
        pulse_in = 4'b0100;
        step();
        pulse_in = '0;
        step();
        check("t4_irq", irq, 1);
        check("t4_id", irq_id, 2);
        irq_ack  = 1'b1;
        pulse_in = 4'b0100;
        step();
        irq_ack  = 1'b0;
        pulse_in = '0;
        check("t4_gap_irq", irq, 0);
        check("t4_pend_kept", pending, 4'b0100);
        step();
        check("t4_idle_irq", irq, 0);
        step();
        check("t4_reirq", irq, 1);
        check("t4_reid", irq_id, 2);

        // Lower-index source arriving in REQ does not re-prioritise.
        pulse_in = 4'b0001;
        step();
        pulse_in = '0;
        step();
        check("t5_lock_id", irq_id, 2);
        check("t5_lock_pend", pending, 4'b0101);
        irq_ack = 1'b1;
        step();
        irq_ack = 1'b0;
        step();
        step();
        check("t5_next_id", irq_id, 0);
        check("t5_next_irq", irq, 1);

        // Reset while in REQ with a pulse in the reset cycle.
        reset    = 1'b1;
        pulse_in = 4'b1000;
        step();
        reset    = 1'b0;
        pulse_in = '0;
        check("t6_irq", irq, 0);
        check("t6_pend", pending, 0);
        check("t6_id", irq_id, 0);
        step();
        check("t6_stay", irq, 0);

        // Two lost events in one cycle count once.
        mask_in  = 4'b0000;
        pulse_in = 4'b0011;
        step();
        check("t7_ovf0", ovf_cnt, 0);
        step();
        pulse_in = '0;
        check("t7_ovf1", ovf_cnt, OVF_EN ? 1 : 0);

        // Saturation: 300 pulses on source 0 without ack.
        pulse_in = 4'b0001;
        for (int i = 0; i < 300; i++) step();
        pulse_in = '0;
        check("t8_pend0", pending[0], 1);
        check("t8_ovf_sat", ovf_cnt, OVF_EN ? 255 : 0);
        check("t8_irq", irq, 0);
        reset = 1'b1;
        step();
        reset = 1'b0;
        check("t8_rst_ovf", ovf_cnt, 0);
        check("t8_rst_irq", irq, 0);
        check("t8_rst_pend", pending, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
